// File: rtl/frame_buf_pkg.sv
// Shared frame buffer constants and the read arbiter state encoding.
package frame_buf_pkg;

    localparam int FRAME_AW      = 9;
    localparam int FRAME_DW      = 9;
    localparam int FRAME_EOF_BIT = 8;

    typedef enum logic {
        ARB_S_ARB    = 1'b0,
        ARB_S_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping at N-1.
module rr_priority_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          any
);

    int cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            for (int j = 0; j < N; j++) begin
                if (!any && (j == cand) && req[j]) begin
                    any       = 1'b1;
                    onehot[j] = 1'b1;
                    idx       = PW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/frame_buf_read_arbiter.sv
// Round-robin arbiter for the frame buffer read port with per-requester lock bursts
// and a lock timeout; read data returns one cycle after the grant.
module frame_buf_read_arbiter
    import frame_buf_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int AW       = FRAME_AW,
    parameter int DW       = FRAME_DW,
    parameter int MAX_LOCK = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  lock,
    input  logic [NREQ*AW-1:0] addr,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  rd_valid,
    output logic [DW-1:0]    rd_data,
    output logic             ram_en,
    output logic [AW-1:0]    ram_addr,
    input  logic [DW-1:0]    ram_rdata,
    output logic             lock_timeout
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_LOCK + 1);

    arb_state_e      state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   owner;
    logic [CW-1:0]   lock_cnt;

    logic [NREQ-1:0] pick_oh;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;
    logic [PW-1:0]   sel_idx;
    logic            req_sel;
    logic            lock_sel;
    logic            lock_pick;
    logic            timeout_hit;
    logic [AW-1:0]   addr_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_addr
        assign addr_arr[i] = addr[i*AW +: AW];
    end

    rr_priority_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Explicit wrap so non-power-of-two NREQ never lands on an unused index.
    function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] i);
        return (i == PW'(NREQ - 1)) ? '0 : i + PW'(1);
    endfunction

    assign req_sel     = req[owner];
    assign lock_sel    = lock[owner];
    assign lock_pick   = lock[pick_idx];
    assign timeout_hit = (state == ARB_S_LOCKED) && lock_sel && (lock_cnt == CW'(MAX_LOCK));

    always_comb begin
        gnt     = '0;
        ram_en  = 1'b0;
        sel_idx = pick_idx;
        if (rst) begin
            gnt    = '0;
            ram_en = 1'b0;
        end else if (state == ARB_S_ARB) begin
            if (pick_any) begin
                gnt    = pick_oh;
                ram_en = 1'b1;
            end
        end else begin
            sel_idx = owner;
            if (req_sel && !timeout_hit) begin
                gnt    = NREQ'(1) << owner;
                ram_en = 1'b1;
            end
        end
    end

    assign ram_addr = addr_arr[sel_idx];
    assign rd_data  = ram_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ARB_S_ARB;
            rr_ptr       <= '0;
            owner        <= '0;
            lock_cnt     <= '0;
            rd_valid     <= '0;
            lock_timeout <= 1'b0;
        end else begin
            rd_valid     <= gnt & {NREQ{ram_en}};
            lock_timeout <= 1'b0;
            case (state)
                ARB_S_ARB: begin
                    if (pick_any) begin
                        if (lock_pick) begin
                            owner    <= pick_idx;
                            lock_cnt <= CW'(1);
                            state    <= ARB_S_LOCKED;
                        end else begin
                            rr_ptr <= rr_next(pick_idx);
                        end
                    end
                end
                ARB_S_LOCKED: begin
                    if (timeout_hit) begin
                        lock_timeout <= 1'b1;
                        lock_cnt     <= '0;
                        rr_ptr       <= rr_next(owner);
                        state        <= ARB_S_ARB;
                    end else if (!lock_sel) begin
                        lock_cnt <= '0;
                        rr_ptr   <= rr_next(owner);
                        state    <= ARB_S_ARB;
                    end else if (lock_cnt != CW'(MAX_LOCK)) begin
                        // Counts held cycles whether or not an access happens.
                        lock_cnt <= lock_cnt + CW'(1);
                    end
                end
                default: state <= ARB_S_ARB;
            endcase
        end
    end

endmodule

// File: doc/frame_buf_read_arbiter.md
Name: frame_buf_read_arbiter

Overview:
- Shares the single read port of the 9-bit-wide frame buffer RAM among NREQ requesters (header decoder, payload dispatcher, debug reader).
- Each cycle it selects one requester round-robin and drives the RAM address and enable.
- It returns the RAM data with a per-requester valid strobe one cycle later.
- A requester can lock the port to read several consecutive words, e.g. header EID followed by the length byte. A lock timeout prevents starvation.

Parameters:
- NREQ, 3, number of requesters (2..8)
- AW, 9, frame buffer address width
- DW, 9, frame buffer data width; bit DW-1 is the end/invalid flag
- MAX_LOCK, 64, maximum consecutive locked grant cycles before forced release

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester read request, level
- lock  in  NREQ  per-requester hold-port request, sampled only while granted
- addr  in  NREQ*AW  flattened read addresses; requester i uses addr[i*AW +: AW]
- gnt  out  NREQ  one-hot grant, combinational, same cycle as the RAM access
- rd_valid  out  NREQ  one-hot, registered; ram_rdata belongs to that requester
- rd_data  out  DW  ram_rdata passed straight through (broadcast)
- ram_en  out  1  RAM read enable
- ram_addr  out  AW  RAM read address
- ram_rdata  in  DW  RAM read data, valid 1 cycle after ram_en
- lock_timeout  out  1  single-cycle pulse when a lock is forcibly broken

Behaviour:
- Reset values:
  - state=ARB, rr_ptr=0, owner=0, lock_cnt=0.
  - rd_valid=0, lock_timeout=0.
  - gnt=0, ram_en=0 (no requester wins during rst).
- State ARB:
  - Pick the first asserted req scanning from rr_ptr upward, with wrap (index NREQ-1 → 0).
  - Winner w: gnt[w]=1, ram_en=1, ram_addr=addr[w].
  - Next cycle: rd_valid[w]=1.
  - If lock[w]=1 in the grant cycle: owner<=w, lock_cnt<=1, go to LOCKED. rr_ptr is unchanged.
  - Otherwise: rr_ptr <= w+1 (mod NREQ).
  - No req asserted: gnt=0, ram_en=0, rr_ptr holds.
- State LOCKED:
  - gnt[owner]=req[owner]. ram_en=req[owner]. Other requesters are ignored.
  - Each cycle with req[owner]=1 increments lock_cnt; rd_valid[owner] follows 1 cycle later.
  - Exit when lock[owner]=0 (sampled in the same cycle as any final access). Go to ARB with rr_ptr <= owner+1. The final access is still performed if req[owner]=1.
  - Exit on timeout: if lock_cnt reaches MAX_LOCK while lock[owner] is still 1:
    - pulse lock_timeout;
    - go to ARB with rr_ptr <= owner+1;
    - no further access is granted in that cycle.
  - A cycle with req[owner]=0 and lock[owner]=1 holds the lock without an access. lock_cnt still increments, so idle holding also times out.
- Throughput: one access per cycle, back-to-back between different requesters with no bubble.
- Ordering: rd_valid is a pure 1-cycle delay of gnt & {NREQ{ram_en}}. Data order per requester equals grant order.
- Stability: requesters must hold addr stable only in the cycle gnt is high. The arbiter does not register addr.
- Reset mid-operation:
  - rd_valid clears on the next edge, even if a read was in flight; the returning data is dropped.
  - Lock is released and the state returns to ARB.
- Width:
  - lock_cnt is $clog2(MAX_LOCK+1) bits and saturates; it never wraps.
  - rr_ptr is $clog2(NREQ) bits and wraps explicitly at NREQ-1 (it does not rely on power-of-two overflow).

Decomposition:
- Shared package frame_buf_pkg:
  - FRAME_AW=9, FRAME_DW=9, FRAME_EOF_BIT=8;
  - state encoding ARB_S_ARB=0, ARB_S_LOCKED=1.
- One natural sub-module: rr_priority_pick.
  - Combinational; inputs req and rr_ptr, outputs one-hot winner and winner index.
  - Reusable by other arbiters in the design.

Test Plan:
1. Single requester: req[0]=1, addr0=9'h005 for 3 cycles → ram_addr 005 each cycle, gnt[0]=1, rd_valid[0]=1 cycles 2–4, rd_data tracks ram_rdata.
2. Round-robin fairness: req=3'b111 constant, no lock → grants cycle 0,1,2,0,1,2; each rd_valid one cycle after its gnt.
3. Lock burst: req[1]=1 and lock[1]=1 for 3 cycles, addr1=10,11,12, while req[0]=1 and req[2]=1 → only gnt[1] for those 3 cycles. Then lock[1]=0 on the 3rd access → next grant goes to requester 2.
4. Lock timeout: MAX_LOCK=4, lock[0] held high → 4 grants to 0, lock_timeout pulses once, next grant goes to requester 1.
5. Wrap: NREQ=3, rr_ptr=2, req=3'b011 → grant 0, then 1.
6. Reset mid-lock: assert rst during LOCKED with a read in flight → rd_valid=0 next cycle. After release, req[2] alone is granted immediately and rr_ptr starts from 0.
